// File: rtl/shifter_pipe.sv
// shifter_pipe: two-stage elastic pipeline computing the ARM operand-2 value
// and shifter carry-out for every addressing mode.
//   Stage 1 decodes the mode into an operation, an effective amount and an
//   operand. Stage 2 performs the shift/rotate and registers the result.
// Ports:
//   clk, reset_n (sync, active-low), flush (sync pipeline clear)
//   in_valid/in_ready   : input handshake
//   mode, rm, rs_amt, imm, c_in, tag_in : operation fields
//   out_valid/out_ready : output handshake
//   result, c_out, tag_out : shifter operand, carry-out, tag
module shifter_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] rm,
  input  logic [7:0]       rs_amt,
  input  logic [11:0]      imm,
  input  logic             c_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic [TAG_W-1:0] tag_out
);

  localparam int SW = $clog2(WIDTH);
  localparam int NW = (SW < 5) ? SW : 5;
  localparam logic [8:0] W9 = 9'(WIDTH);
  localparam logic [SW-1:0] ONE_SW = SW'(1);

  typedef enum logic [2:0] {OP_PASS, OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX} op_e;

  function automatic op_e ty2op(input logic [1:0] ty);
    case (ty)
      2'b00:   return OP_LSL;
      2'b01:   return OP_LSR;
      2'b10:   return OP_ASR;
      default: return OP_ROR;
    endcase
  endfunction

  // Zero-extended immediates
  logic [WIDTH-1:0] imm8_ext;
  logic [WIDTH-1:0] imm12_ext;

  if (WIDTH > 8) begin : g_imm8_wide
    assign imm8_ext = {{(WIDTH-8){1'b0}}, imm[7:0]};
  end else begin : g_imm8_narrow
    assign imm8_ext = imm[7:0];
  end

  if (WIDTH >= 12) begin : g_imm12_wide
    assign imm12_ext = {{(WIDTH-12){1'b0}}, imm};
  end else begin : g_imm12_narrow
    assign imm12_ext = imm[WIDTH-1:0];
  end

  // Handshake
  logic vld_p1_q, vld_p2_q;
  logic adv_p1, adv_p2, accept;

  assign adv_p2   = !vld_p2_q || out_ready;
  assign adv_p1   = !vld_p1_q || adv_p2;
  assign in_ready = adv_p1 && !flush && reset_n;
  assign accept   = in_valid && in_ready;

  // ---- Stage 0 -> 1: decode ----
  op_e              op_d;
  logic [8:0]       amt_d;
  logic [WIDTH-1:0] opnd_d;
  logic [8:0]       rot_amt;
  logic [NW-1:0]    imm_n;

  // Rotation of 2*imm[11:8] reduced modulo WIDTH (power of two).
  assign rot_amt = 9'({imm[11:8], 1'b0}) & (W9 - 9'd1);
  assign imm_n   = imm[7 +: NW];

  always_comb begin
    op_d   = OP_PASS;
    amt_d  = '0;
    opnd_d = rm;
    case (mode)
      3'b000: begin
        opnd_d = imm8_ext;
        if (rot_amt != '0) begin
          op_d  = OP_ROR;
          amt_d = rot_amt;
        end
      end
      3'b010: opnd_d = imm12_ext;
      3'b011: begin
        // #0 encodings: LSL#0 is a move, LSR/ASR#0 mean #WIDTH, ROR#0 is RRX.
        if (imm_n == '0) begin
          case (imm[6:5])
            2'b01: begin op_d = OP_LSR; amt_d = W9; end
            2'b10: begin op_d = OP_ASR; amt_d = W9; end
            2'b11: op_d = OP_RRX;
            default: op_d = OP_PASS;
          endcase
        end else begin
          op_d  = ty2op(imm[6:5]);
          amt_d = 9'(imm_n);
        end
      end
      3'b100: begin
        if (rs_amt != 8'd0) begin
          op_d  = ty2op(imm[6:5]);
          amt_d = {1'b0, rs_amt};
        end
      end
      default: op_d = OP_PASS;
    endcase
  end

  op_e              op_p1_q;
  logic [8:0]       amt_p1_q;
  logic [WIDTH-1:0] opnd_p1_q;
  logic             cin_p1_q;
  logic [TAG_W-1:0] tag_p1_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1_q   <= op_d;
      amt_p1_q  <= amt_d;
      opnd_p1_q <= opnd_d;
      cin_p1_q  <= c_in;
      tag_p1_q  <= tag_in;
    end
  end

  // ---- Stage 1 -> 2: shift ----
  logic [WIDTH-1:0]        res_d;
  logic                    c_d;
  logic signed [WIDTH-1:0] opnd_s;
  logic [SW-1:0]           sh, shn, shm1;
  logic                    below_w, at_w;

  assign opnd_s  = opnd_p1_q;
  assign sh      = amt_p1_q[SW-1:0];
  assign shn     = '0 - sh;          // WIDTH - sh for sh in 1..WIDTH-1
  assign shm1    = sh - ONE_SW;
  assign below_w = amt_p1_q < W9;
  assign at_w    = amt_p1_q == W9;

  // Counts >= WIDTH are resolved explicitly so the shift operators only
  // ever see amounts in 1..WIDTH-1.
  always_comb begin
    res_d = opnd_p1_q;
    c_d   = cin_p1_q;
    case (op_p1_q)
      OP_LSL: begin
        if (below_w) begin
          res_d = opnd_p1_q << sh;
          c_d   = opnd_p1_q[shn];
        end else begin
          res_d = '0;
          c_d   = at_w ? opnd_p1_q[0] : 1'b0;
        end
      end
      OP_LSR: begin
        if (below_w) begin
          res_d = opnd_p1_q >> sh;
          c_d   = opnd_p1_q[shm1];
        end else begin
          res_d = '0;
          c_d   = at_w ? opnd_p1_q[WIDTH-1] : 1'b0;
        end
      end
      OP_ASR: begin
        if (below_w) begin
          res_d = opnd_s >>> sh;
          c_d   = opnd_p1_q[shm1];
        end else begin
          res_d = {WIDTH{opnd_p1_q[WIDTH-1]}};
          c_d   = opnd_p1_q[WIDTH-1];
        end
      end
      OP_ROR: begin
        if (sh == '0) begin
          res_d = opnd_p1_q;
          c_d   = opnd_p1_q[WIDTH-1];
        end else begin
          res_d = (opnd_p1_q >> sh) | (opnd_p1_q << shn);
          c_d   = opnd_p1_q[shm1];
        end
      end
      OP_RRX: begin
        res_d = {cin_p1_q, opnd_p1_q[WIDTH-1:1]};
        c_d   = opnd_p1_q[0];
      end
      default: begin
        res_d = opnd_p1_q;
        c_d   = cin_p1_q;
      end
    endcase
  end

  logic [WIDTH-1:0] res_p2_q;
  logic             c_p2_q;
  logic [TAG_W-1:0] tag_p2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_p2_q <= '0;
      c_p2_q   <= 1'b0;
      tag_p2_q <= '0;
    end else if (adv_p2 && vld_p1_q) begin
      res_p2_q <= res_d;
      c_p2_q   <= c_d;
      tag_p2_q <= tag_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (flush) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (adv_p1) vld_p1_q <= accept;
      if (adv_p2) vld_p2_q <= vld_p1_q;
    end
  end

  assign out_valid = vld_p2_q;
  assign result    = res_p2_q;
  assign c_out     = c_p2_q;
  assign tag_out   = tag_p2_q;

endmodule

// File: tb/tb_shifter_pipe.sv
module tb_shifter_pipe;

  logic        clk;
  logic        reset_n, flush, in_valid, in_ready;
  logic [2:0]  mode;
  logic [31:0] rm;
  logic [7:0]  rs_amt;
  logic [11:0] imm;
  logic        c_in;
  logic [3:0]  tag_in;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        c_out;
  logic [3:0]  tag_out;

  shifter_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .rm(rm), .rs_amt(rs_amt), .imm(imm), .c_in(c_in), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .c_out(c_out), .tag_out(tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference model: straight from the architectural rules, using wide
  // vectors so every shifted-out bit is simply read from past the edge.
  function automatic void shift_ref(input logic [1:0] ty, input logic [31:0] x, input int a,
                                    output logic [31:0] r, output logic c);
    logic [95:0] w;
    logic signed [64:0] v;
    logic [63:0] d;
    int k;
    r = x;
    c = 1'b0;
    case (ty)
      2'd0: begin w = {64'd0, x} << a; r = w[31:0]; c = w[32]; end
      2'd1: begin w = {x, 64'd0} >> a; r = w[95:64]; c = w[63]; end
      2'd2: begin
        v = {{32{x[31]}}, x, 1'b0};
        v = v >>> ((a > 32) ? 32 : a);
        r = v[32:1];
        c = v[0];
      end
      default: begin
        k = a % 32;
        if (k == 0) begin r = x; c = x[31]; end
        else begin d = {x, x} >> k; r = d[31:0]; c = r[31]; end
      end
    endcase
  endfunction

  function automatic void model(input logic [2:0] m, input logic [31:0] x, input logic [7:0] s,
                                input logic [11:0] i, input logic ci,
                                output logic [31:0] r, output logic c);
    int rot;
    logic [63:0] d;
    r = x;
    c = ci;
    case (m)
      3'd0: begin
        rot = 2 * int'(i[11:8]);
        if (rot == 0) r = {24'd0, i[7:0]};
        else begin
          d = {24'd0, i[7:0], 24'd0, i[7:0]} >> rot;
          r = d[31:0];
          c = r[31];
        end
      end
      3'd2: r = {20'd0, i};
      3'd3: begin
        if (i[11:7] == 5'd0) begin
          case (i[6:5])
            2'd1: shift_ref(2'd1, x, 32, r, c);
            2'd2: shift_ref(2'd2, x, 32, r, c);
            2'd3: begin r = {ci, x[31:1]}; c = x[0]; end
            default: ;
          endcase
        end else shift_ref(i[6:5], x, int'(i[11:7]), r, c);
      end
      3'd4: if (s != 8'd0) shift_ref(i[6:5], x, int'(s), r, c);
      default: ;
    endcase
  endfunction

  typedef struct packed {
    logic [31:0] r;
    logic        c;
    logic [3:0]  t;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] seen_tags[$];

  logic        stall_prev = 1'b0;
  logic [31:0] prev_res;
  logic        prev_c;
  logic [3:0]  prev_tag;

  // Compare process: handshakes observed mid-cycle take effect at the next edge.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] er;
    logic ec;
    if (stall_prev) begin
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_result", 64'(result), 64'(prev_res));
      chk("hold_c_out", 64'(c_out), 64'(prev_c));
      chk("hold_tag", 64'(tag_out), 64'(prev_tag));
    end
    if (flush || !reset_n) chk("in_ready_blocked", 64'(in_ready), 64'(0));
    if (out_valid && out_ready) begin
      seen_tags.push_back(tag_out);
      chk("sb_nonempty", 64'(sbq.size() != 0), 64'(1));
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("result", 64'(result), 64'(e.r));
        chk("c_out", 64'(c_out), 64'(e.c));
        chk("tag_out", 64'(tag_out), 64'(e.t));
      end
    end
    if (in_valid && in_ready) begin
      model(mode, rm, rs_amt, imm, c_in, er, ec);
      e.r = er; e.c = ec; e.t = tag_in;
      sbq.push_back(e);
    end
    if (!reset_n || flush) sbq.delete();
    stall_prev = out_valid && !out_ready && reset_n && !flush;
    prev_res = result;
    prev_c = c_out;
    prev_tag = tag_out;
  end

  task automatic send(input logic [2:0] m, input logic [31:0] x, input logic [7:0] s,
                      input logic [11:0] i, input logic ci, input logic [3:0] t);
    bit acc;
    acc = 1'b0;
    mode = m; rm = x; rs_amt = s; imm = i; c_in = ci; tag_in = t; in_valid = 1'b1;
    for (int k = 0; k < 64 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    chk("send_accept", 64'(acc), 64'(1));
  endtask

  task automatic drain();
    int k;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    k = 0;
    while (sbq.size() != 0 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    @(posedge clk); #1;
    chk("drain_empty", 64'(sbq.size()), 64'(0));
  endtask

  typedef struct packed {
    logic [2:0]  m;
    logic [31:0] x;
    logic [7:0]  s;
    logic [11:0] i;
    logic        ci;
    logic [31:0] er;
    logic        ec;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] mr;
    logic mc;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mode = '0; rm = '0; rs_amt = '0; imm = '0; c_in = 1'b0; tag_in = '0;

    vecs[0]  = '{3'd0, 32'h0,        8'd0,  12'h4FF, 1'b0, 32'hFF000000, 1'b1};
    vecs[1]  = '{3'd0, 32'h0,        8'd0,  12'h0AB, 1'b1, 32'h000000AB, 1'b1};
    vecs[2]  = '{3'd3, 32'h80000001, 8'd0,  12'h020, 1'b0, 32'h00000000, 1'b1};
    vecs[3]  = '{3'd3, 32'h80000001, 8'd0,  12'h040, 1'b0, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{3'd3, 32'h80000001, 8'd0,  12'h060, 1'b1, 32'hC0000000, 1'b1};
    vecs[5]  = '{3'd3, 32'h80000001, 8'd0,  12'h080, 1'b0, 32'h00000002, 1'b1};
    vecs[6]  = '{3'd4, 32'h00000001, 8'd0,  12'h000, 1'b1, 32'h00000001, 1'b1};
    vecs[7]  = '{3'd4, 32'h00000001, 8'd31, 12'h000, 1'b0, 32'h80000000, 1'b0};
    vecs[8]  = '{3'd4, 32'h00000001, 8'd32, 12'h000, 1'b0, 32'h00000000, 1'b1};
    vecs[9]  = '{3'd4, 32'h00000001, 8'd33, 12'h000, 1'b1, 32'h00000000, 1'b0};
    vecs[10] = '{3'd4, 32'h80000000, 8'd64, 12'h060, 1'b0, 32'h80000000, 1'b1};
    vecs[11] = '{3'd2, 32'h12345678, 8'd0,  12'hFFF, 1'b0, 32'h00000FFF, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_c_out", 64'(c_out), 64'(0));
    chk("rst_tag_out", 64'(tag_out), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));

    // Pin the model against hand-computed values
    foreach (vecs[j]) begin
      model(vecs[j].m, vecs[j].x, vecs[j].s, vecs[j].i, vecs[j].ci, mr, mc);
      chk($sformatf("model_res_%0d", j), 64'(mr), 64'(vecs[j].er));
      chk($sformatf("model_c_%0d", j), 64'(mc), 64'(vecs[j].ec));
    end

    @(posedge clk); #1;
    reset_n = 1'b1; out_ready = 1'b1;

    // Directed vectors through the DUT
    foreach (vecs[j]) send(vecs[j].m, vecs[j].x, vecs[j].s, vecs[j].i, vecs[j].ci, 4'(j));
    drain();

    // Randomized traffic with random stalls and flushes
    for (int cyc = 0; cyc < 3000; cyc++) begin
      out_ready = ($urandom_range(3) != 0);
      flush = ($urandom_range(40) == 0);
      in_valid = ($urandom_range(3) != 0);
      mode = 3'($urandom_range(7));
      rm = $urandom;
      case ($urandom_range(3))
        0: rm = 32'h80000000;
        1: rm = 32'h00000001;
        default: ;
      endcase
      case ($urandom_range(5))
        0: rs_amt = 8'd0;
        1: rs_amt = 8'd32;
        2: rs_amt = 8'($urandom_range(33));
        3: rs_amt = 8'd64;
        default: rs_amt = 8'($urandom);
      endcase
      imm = 12'($urandom);
      c_in = 1'($urandom);
      tag_in = 4'($urandom);
      @(posedge clk); #1;
    end
    drain();

    // Back-to-back with a 3-cycle output stall
    seen_tags.delete();
    out_ready = 1'b1;
    fork
      begin
        for (int t = 1; t <= 4; t++) send(3'd4, $urandom, 8'($urandom), 12'($urandom), 1'b0, 4'(t));
        in_valid = 1'b0;
      end
      begin
        int k;
        k = 0;
        while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
        chk("stall_first_valid", 64'(out_valid), 64'(1));
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'(0));
          chk("stall_tag", 64'(tag_out), 64'(1));
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("order_count", 64'(seen_tags.size()), 64'(4));
    foreach (seen_tags[j]) chk($sformatf("order_tag_%0d", j), 64'(seen_tags[j]), 64'(j + 1));

    // Flush with both stages full and an input offered
    out_ready = 1'b0;
    send(3'd1, 32'hAAAA5555, 8'd0, 12'd0, 1'b0, 4'd7);
    send(3'd1, 32'h5555AAAA, 8'd0, 12'd0, 1'b0, 4'd8);
    mode = 3'd1; rm = 32'hDEADBEEF; tag_in = 4'd9; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_pre_valid", 64'(out_valid), 64'(1));
    chk("flush_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    chk("flush_ready_after", 64'(in_ready), 64'(1));
    repeat (4) begin
      @(negedge clk);
      chk("flush_no_ghost", 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;

    // Reset mid-stream
    out_ready = 1'b0;
    send(3'd2, 32'h0, 8'd0, 12'h123, 1'b1, 4'd10);
    send(3'd2, 32'h0, 8'd0, 12'h456, 1'b1, 4'd11);
    in_valid = 1'b0; reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; out_ready = 1'b1;
    mode = 3'd0; imm = 12'h4FF; c_in = 1'b0; tag_in = 4'd12; in_valid = 1'b1;
    @(negedge clk);
    chk("mrst_out_valid", 64'(out_valid), 64'(0));
    chk("mrst_result", 64'(result), 64'(0));
    chk("mrst_c_out", 64'(c_out), 64'(0));
    chk("mrst_tag_out", 64'(tag_out), 64'(0));
    chk("mrst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    chk("lat_cycle2_valid", 64'(out_valid), 64'(1));
    chk("lat_cycle2_tag", 64'(tag_out), 64'(12));
    chk("lat_cycle2_result", 64'(result), 64'(32'hFF000000));
    chk("lat_cycle2_c_out", 64'(c_out), 64'(1));
    @(posedge clk); #1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shifter_pipe.md
Name: shifter_pipe

Overview:
- Parametrised, pipelined successor to the combinational operand-2 shifter in the datapath.
- Computes the ARM shifter operand and the shifter carry-out for all addressing modes.
- Adds register-specified shift amounts, RRX and #0 special encodings, and carry-out.
- Two-stage valid/ready elastic pipeline with flush, placed between register read and the ALU.

Parameters:
- WIDTH, 32, datapath width; power of two, 8..64. SW = log2(WIDTH).
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  operation offered
- in_ready  out  1  operation accepted when in_valid && in_ready
- mode  in  3  000 rot-imm, 001 reg, 010 zext-imm12, 011 imm-shift, 100 reg-shift
- rm  in  WIDTH  source operand
- rs_amt  in  8  Rs[7:0]; shift amount for mode 100
- imm  in  12  instruction I[11:0]
- c_in  in  1  current CPSR C flag
- tag_in  in  TAG_W  opaque tag
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts when out_valid && out_ready
- result  out  WIDTH  shifter operand
- c_out  out  1  shifter carry-out
- tag_out  out  TAG_W  tag of result

Behaviour:
- Reset (reset_n=0 at clk edge): both stage valids 0; result, c_out and tag_out are 0. in_ready is 0 during the reset cycle.
- Stage 1 (S1) registers:
  - decoded type: LSL/LSR/ASR/ROR/RRX/passthru
  - effective amount, 9 bits
  - operand
  - c_in and tag
- Stage 2 (S2) registers the computed result, c_out and tag.
- Latency: 2 cycles from acceptance to out_valid when unstalled. Throughput: 1 operation per cycle.
- Handshake:
  - S2 advances if !s2_valid || out_ready.
  - S1 advances if !s1_valid || S2 advances.
  - in_ready = S1 advances && !flush.
- While out_valid && !out_ready, result, c_out and tag_out hold stable.
- flush:
  - Clears s1_valid and s2_valid at the next edge.
  - in_ready is forced to 0, so a same-cycle input is dropped.
  - A stalled output is discarded.
  - reset_n has priority over flush.
- Mode 000, rot-imm:
  - result = zext(imm[7:0]) rotated right by 2*imm[11:8], mod WIDTH.
  - c_out = c_in if rotation is 0, else result[WIDTH-1].
- Mode 001, reg: result = rm; c_out = c_in.
- Mode 010, zext-imm12: result = zext(imm); c_out = c_in.
- Mode 011, imm-shift: shift type = imm[6:5], amount n = imm[11:7] (width min(5,SW)).
  - LSL #0: rm, c_in.
  - LSL #n: rm<<n; c_out = rm[WIDTH-n].
  - LSR #0 means LSR #WIDTH: 0; c_out = rm[WIDTH-1].
  - LSR #n: rm>>n; c_out = rm[n-1].
  - ASR #0 means ASR #WIDTH: all bits = rm[WIDTH-1]; c_out = rm[WIDTH-1].
  - ASR #n: arithmetic shift; c_out = rm[n-1].
  - ROR #0 means RRX: {c_in, rm[WIDTH-1:1]}; c_out = rm[0].
  - ROR #n: rotate; c_out = rm[n-1].
- Mode 100, reg-shift: type = imm[6:5], amount a = rs_amt (0..255).
  - a==0: rm, c_in (all types).
  - LSL: a<WIDTH normal; a==WIDTH gives 0, c_out = rm[0]; a>WIDTH gives 0, 0.
  - LSR: a<WIDTH normal; a==WIDTH gives 0, c_out = rm[WIDTH-1]; a>WIDTH gives 0, 0.
  - ASR: a>=WIDTH gives sign-fill, c_out = rm[WIDTH-1].
  - ROR: a mod WIDTH == 0 with a!=0 gives rm, c_out = rm[WIDTH-1]; else rotate by a mod WIDTH, c_out = result[WIDTH-1].
- Modes 101..111 are reserved: result = rm, c_out = c_in. They do not stall.
- Widths:
  - All shifts are computed without Verilog over-shift ambiguity.
  - Shift counts ≥ WIDTH never reach the shift operator; they are handled explicitly.
  - No intermediate truncation of the 8-bit immediate.
- Simultaneous accept and output-drain in one cycle: both occur; no bubble inserted.

Test Plan:
- Rot-imm: mode=000, imm=0x4FF, c_in=0 -> 2 cycles later result=0xFF000000, c_out=1. imm=0x0AB, c_in=1 -> 0x000000AB, c_out=1.
- Imm-shift specials: rm=0x80000001.
  - LSR#0 -> result=0, c_out=1.
  - ASR#0 -> 0xFFFFFFFF, 1.
  - ROR#0 with c_in=1 -> 0xC0000000, 1.
  - LSL#1 -> 0x00000002, 1.
- Reg-shift amounts: rm=0x00000001, LSL.
  - rs_amt=0 -> 1, c_in.
  - rs_amt=31 -> 0x80000000, 0.
  - rs_amt=32 -> 0, c_out=1.
  - rs_amt=33 -> 0, 0.
  - ROR with rs_amt=64 and rm=0x80000000 -> 0x80000000, c_out=1.
- Back-to-back and stall: 4 consecutive accepts with tags 1..4; hold out_ready=0 for 3 cycles after the first result.
  - in_ready drops once both stages are full.
  - result and tag_out stay stable while stalled.
  - Tags emerge in order 1,2,3,4 with no loss or duplication.
- Flush: flush=1 with both stages valid and in_valid=1 -> next cycle out_valid=0, in_ready=1. The input offered during the flush cycle never appears.
- Reset mid-stream: reset_n=0 for one edge with both stages full -> out_valid=0, result=0, c_out=0, tag_out=0. The first post-reset accept appears exactly 2 cycles later.
